affine_mv_gen_seq: RTL and testbench

- Parametrised successor of the 4-parameter MV generator datapath: one generator for both 4- and 6-parameter affine mode over a GRID_W x GRID_H grid of subblocks.
- On START it latches the coordinates and CPMVs, computes the affine gradients, then walks the grid in raster order, one subblock MV per cycle.
- Each MV is presented on a valid/ready output port, split into integer and fraction, with per-axis interpolation flags.
- Position: between the CPMV source and the interpolation controller. Uses incremental adders, no multipliers.

---
 rtl/affine_mv_gen_seq_if.sv | 35 +++
 rtl/affine_mv_gen_seq.sv | 219 +++++++++++++++++++++
 tb/tb_affine_mv_gen_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/affine_mv_gen_seq_if.sv
// rtl/affine_mv_gen_seq_if.sv - subblock MV output stream of the affine MV generator
interface affine_mv_gen_seq_if #(
  parameter int COORD_W   = 8,
  parameter int MV_W      = 8,
  parameter int FRAC_BITS = 4
);
  localparam int OUT_W = MV_W + FRAC_BITS + 7;
  localparam int INT_W = OUT_W - FRAC_BITS;

  logic               OUT_READY;
  logic               OUT_VALID;
  logic               OUT_LAST;
  logic [COORD_W-1:0] OUT_X;
  logic [COORD_W-1:0] OUT_Y;
  logic [INT_W-1:0]   OUT_MV_X_INTEGER;
  logic [FRAC_BITS-1:0] OUT_MV_X_FRAC;
  logic [INT_W-1:0]   OUT_MV_Y_INTEGER;
  logic [FRAC_BITS-1:0] OUT_MV_Y_FRAC;
  logic               INTERP_X;
  logic               INTERP_Y;

  modport master (
    input  OUT_READY,
    output OUT_VALID, OUT_LAST, OUT_X, OUT_Y,
    output OUT_MV_X_INTEGER, OUT_MV_X_FRAC, OUT_MV_Y_INTEGER, OUT_MV_Y_FRAC,
    output INTERP_X, INTERP_Y
  );

  modport slave (
    output OUT_READY,
    input  OUT_VALID, OUT_LAST, OUT_X, OUT_Y,
    input  OUT_MV_X_INTEGER, OUT_MV_X_FRAC, OUT_MV_Y_INTEGER, OUT_MV_Y_FRAC,
    input  INTERP_X, INTERP_Y
  );
endinterface

// File: rtl/affine_mv_gen_seq.sv
// rtl/affine_mv_gen_seq.sv - 4/6-parameter affine subblock MV generator, raster walk
module affine_mv_gen_seq #(
  parameter int COORD_W   = 8,
  parameter int MV_W      = 8,
  parameter int FRAC_BITS = 4,
  parameter int GRID_W    = 4,
  parameter int GRID_H    = 4
) (
  input  logic                 CLK,
  input  logic                 RST_ASYNC,
  input  logic                 START,
  input  logic                 MODE_6PARAM,
  input  logic [COORD_W-1:0]   COORD_X,
  input  logic [COORD_W-1:0]   COORD_Y,
  input  logic [2*MV_W-1:0]    CPMV_0,
  input  logic [2*MV_W-1:0]    CPMV_1,
  input  logic [2*MV_W-1:0]    CPMV_2,
  output logic                 BUSY,
  output logic                 DONE,
  affine_mv_gen_seq_if.master  mv_out
);
  localparam int OUT_W = MV_W + FRAC_BITS + 7;
  localparam int IW    = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int JW    = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam logic [IW-1:0] I_MAX = IW'(GRID_W - 1);
  localparam logic [JW-1:0] J_MAX = JW'(GRID_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [COORD_W-1:0]  cx_q, cx_d, cy_q, cy_d;
  logic [2*MV_W-1:0]   mv0_q, mv0_d, mv1_q, mv1_d, mv2_q, mv2_d;
  logic [MV_W:0]       ax_q, ax_d, ay_q, ay_d, bx_q, bx_d, by_q, by_d;
  logic [IW-1:0]       i_q, i_d;
  logic [JW-1:0]       j_q, j_d;
  logic [OUT_W-1:0]    row_h_q, row_h_d, row_v_q, row_v_d;
  logic [OUT_W-1:0]    run_h_q, run_h_d, run_v_q, run_v_d;
  logic [COORD_W-1:0]  out_x_q, out_x_d, out_y_q, out_y_d;
  logic                valid_q, valid_d, last_q, last_d;
  logic                busy_q, busy_d, done_q, done_d;

  function automatic logic [MV_W:0] grad(input logic [MV_W-1:0] a, input logic [MV_W-1:0] b);
    return {a[MV_W-1], a} - {b[MV_W-1], b};
  endfunction

  function automatic logic [OUT_W-1:0] sx_grad(input logic [MV_W:0] g);
    return {{(OUT_W-MV_W-1){g[MV_W]}}, g};
  endfunction

  function automatic logic [OUT_W-1:0] base_mv(input logic [MV_W-1:0] m);
    return {{(OUT_W-MV_W-FRAC_BITS){m[MV_W-1]}}, m, {FRAC_BITS{1'b0}}};
  endfunction

  logic [MV_W-1:0] h0, v0, h1, v1, h2, v2;
  logic [MV_W:0]   ax_n, ay_n, bx_n, by_n;

  assign h0 = mv0_q[2*MV_W-1:MV_W];
  assign v0 = mv0_q[MV_W-1:0];
  assign h1 = mv1_q[2*MV_W-1:MV_W];
  assign v1 = mv1_q[MV_W-1:0];
  assign h2 = mv2_q[2*MV_W-1:MV_W];
  assign v2 = mv2_q[MV_W-1:0];

  // 4-param mode derives the vertical gradient as a rotation of the horizontal one
  assign ax_n = grad(h1, h0);
  assign ay_n = grad(v1, v0);
  assign bx_n = mode_q ? grad(h2, h0) : -ay_n;
  assign by_n = mode_q ? grad(v2, v0) : ax_n;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    mv0_d   = mv0_q;
    mv1_d   = mv1_q;
    mv2_d   = mv2_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    bx_d    = bx_q;
    by_d    = by_q;
    i_d     = i_q;
    j_d     = j_q;
    row_h_d = row_h_q;
    row_v_d = row_v_q;
    run_h_d = run_h_q;
    run_v_d = run_v_q;
    out_x_d = out_x_q;
    out_y_d = out_y_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          mode_d  = MODE_6PARAM;
          cx_d    = COORD_X;
          cy_d    = COORD_Y;
          mv0_d   = CPMV_0;
          mv1_d   = CPMV_1;
          mv2_d   = CPMV_2;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ax_d    = ax_n;
        ay_d    = ay_n;
        bx_d    = bx_n;
        by_d    = by_n;
        i_d     = '0;
        j_d     = '0;
        row_h_d = base_mv(h0);
        row_v_d = base_mv(v0);
        run_h_d = base_mv(h0);
        run_v_d = base_mv(v0);
        out_x_d = cx_q;
        out_y_d = cy_q;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (mv_out.OUT_READY) begin
          if (last_q) begin
            state_d = S_DONE;
          end else if (i_q != I_MAX) begin
            i_d     = i_q + IW'(1);
            run_h_d = run_h_q + sx_grad(ax_q);
            run_v_d = run_v_q + sx_grad(ay_q);
            out_x_d = out_x_q + COORD_W'(1);
          end else begin
            // row wrap: the running accumulator restarts from the new row origin
            i_d     = '0;
            j_d     = j_q + JW'(1);
            row_h_d = row_h_q + sx_grad(bx_q);
            row_v_d = row_v_q + sx_grad(by_q);
            run_h_d = row_h_q + sx_grad(bx_q);
            run_v_d = row_v_q + sx_grad(by_q);
            out_x_d = cx_q;
            out_y_d = out_y_q + COORD_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    valid_d = (state_d == S_RUN);
    last_d  = (state_d == S_RUN) && (i_d == I_MAX) && (j_d == J_MAX);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      mv0_q   <= '0;
      mv1_q   <= '0;
      mv2_q   <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      row_h_q <= '0;
      row_v_q <= '0;
      run_h_q <= '0;
      run_v_q <= '0;
      out_x_q <= '0;
      out_y_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      mv0_q   <= mv0_d;
      mv1_q   <= mv1_d;
      mv2_q   <= mv2_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      i_q     <= i_d;
      j_q     <= j_d;
      row_h_q <= row_h_d;
      row_v_q <= row_v_d;
      run_h_q <= run_h_d;
      run_v_q <= run_v_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mv_out.OUT_VALID        = valid_q;
  assign mv_out.OUT_LAST         = last_q;
  assign mv_out.OUT_X            = out_x_q;
  assign mv_out.OUT_Y            = out_y_q;
  assign mv_out.OUT_MV_X_INTEGER = run_h_q[OUT_W-1:FRAC_BITS];
  assign mv_out.OUT_MV_X_FRAC    = run_h_q[FRAC_BITS-1:0];
  assign mv_out.OUT_MV_Y_INTEGER = run_v_q[OUT_W-1:FRAC_BITS];
  assign mv_out.OUT_MV_Y_FRAC    = run_v_q[FRAC_BITS-1:0];
  assign mv_out.INTERP_X         = |run_h_q[FRAC_BITS-1:0];
  assign mv_out.INTERP_Y         = |run_v_q[FRAC_BITS-1:0];
  assign BUSY                    = busy_q;
  assign DONE                    = done_q;
endmodule

// File: tb/tb_affine_mv_gen_seq.sv
// tb/tb_affine_mv_gen_seq.sv - directed vector bench for affine_mv_gen_seq (4x4 and 1x1 builds)
module tb_affine_mv_gen_seq;
  logic        CLK = 1'b0;
  logic        RST_ASYNC = 1'b1;
  logic        start, start1, mode;
  logic [7:0]  cx, cy;
  logic [15:0] cp0, cp1, cp2;
  logic        busy, done, busy1, done1;
  int          n_tests = 0;
  int          n_fail  = 0;

  affine_mv_gen_seq_if #(.COORD_W(8), .MV_W(8), .FRAC_BITS(4)) mv_if ();
  affine_mv_gen_seq_if #(.COORD_W(8), .MV_W(8), .FRAC_BITS(4)) mv1_if ();

  affine_mv_gen_seq #(.COORD_W(8), .MV_W(8), .FRAC_BITS(4), .GRID_W(4), .GRID_H(4)) dut (
    .CLK(CLK), .RST_ASYNC(RST_ASYNC), .START(start), .MODE_6PARAM(mode),
    .COORD_X(cx), .COORD_Y(cy), .CPMV_0(cp0), .CPMV_1(cp1), .CPMV_2(cp2),
    .BUSY(busy), .DONE(done), .mv_out(mv_if)
  );

  affine_mv_gen_seq #(.COORD_W(8), .MV_W(8), .FRAC_BITS(4), .GRID_W(1), .GRID_H(1)) dut1 (
    .CLK(CLK), .RST_ASYNC(RST_ASYNC), .START(start1), .MODE_6PARAM(mode),
    .COORD_X(cx), .COORD_Y(cy), .CPMV_0(cp0), .CPMV_1(cp1), .CPMV_2(cp2),
    .BUSY(busy1), .DONE(done1), .mv_out(mv1_if)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        mode;
    logic [7:0]  cx, cy;
    logic [7:0]  h0, v0, h1, v1, h2, v2;
    int          idx;
    logic [7:0]  ex, ey;
    logic [14:0] eix;
    logic [3:0]  efx;
    logic [14:0] eiy;
    logic [3:0]  efy;
    logic        ix, iy, el;
    int          stall_at;
    int          restart_at;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_fields(input int id, input vec_t v);
    check($sformatf("v%0d out_x", id), 32'(mv_if.OUT_X), 32'(v.ex));
    check($sformatf("v%0d out_y", id), 32'(mv_if.OUT_Y), 32'(v.ey));
    check($sformatf("v%0d int_x", id), 32'(mv_if.OUT_MV_X_INTEGER), 32'(v.eix));
    check($sformatf("v%0d frac_x", id), 32'(mv_if.OUT_MV_X_FRAC), 32'(v.efx));
    check($sformatf("v%0d int_y", id), 32'(mv_if.OUT_MV_Y_INTEGER), 32'(v.eiy));
    check($sformatf("v%0d frac_y", id), 32'(mv_if.OUT_MV_Y_FRAC), 32'(v.efy));
    check($sformatf("v%0d interp_x", id), 32'(mv_if.INTERP_X), 32'(v.ix));
    check($sformatf("v%0d interp_y", id), 32'(mv_if.INTERP_Y), 32'(v.iy));
    check($sformatf("v%0d last", id), 32'(mv_if.OUT_LAST), 32'(v.el));
  endtask

  task automatic launch(input vec_t v);
    mode = v.mode;
    cx   = v.cx;
    cy   = v.cy;
    cp0  = {v.h0, v.v0};
    cp1  = {v.h1, v.v1};
    cp2  = {v.h2, v.v2};
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int cnt, cyc, first, lastv, last_at, done_cyc;
    bit stalled;
    logic [7:0]  hx, hy;
    logic [14:0] hix, hiy;
    logic [3:0]  hfx, hfy;
    cnt = 0; cyc = 0; first = -1; lastv = -1; last_at = -1; done_cyc = -1; stalled = 1'b0;
    mv_if.OUT_READY = 1'b1;
    launch(v);
    while (done_cyc < 0 && cyc < 200) begin
      if (cyc == 0) begin
        check($sformatf("v%0d load_valid", id), 32'(mv_if.OUT_VALID), 32'd0);
        check($sformatf("v%0d load_busy", id), 32'(busy), 32'd1);
      end
      if (cyc == 1) check($sformatf("v%0d first_valid", id), 32'(mv_if.OUT_VALID), 32'd1);
      if (mv_if.OUT_VALID) begin
        if (cnt == v.stall_at && !stalled) begin
          stalled = 1'b1;
          hx = mv_if.OUT_X; hy = mv_if.OUT_Y;
          hix = mv_if.OUT_MV_X_INTEGER; hfx = mv_if.OUT_MV_X_FRAC;
          hiy = mv_if.OUT_MV_Y_INTEGER; hfy = mv_if.OUT_MV_Y_FRAC;
          mv_if.OUT_READY = 1'b0;
          for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            cyc++;
            check($sformatf("v%0d hold%0d valid", id, k), 32'(mv_if.OUT_VALID), 32'd1);
            check($sformatf("v%0d hold%0d x", id, k), 32'(mv_if.OUT_X), 32'(hx));
            check($sformatf("v%0d hold%0d y", id, k), 32'(mv_if.OUT_Y), 32'(hy));
            check($sformatf("v%0d hold%0d mvx", id, k),
                  32'({mv_if.OUT_MV_X_INTEGER, mv_if.OUT_MV_X_FRAC}), 32'({hix, hfx}));
            check($sformatf("v%0d hold%0d mvy", id, k),
                  32'({mv_if.OUT_MV_Y_INTEGER, mv_if.OUT_MV_Y_FRAC}), 32'({hiy, hfy}));
          end
          mv_if.OUT_READY = 1'b1;
        end
        if (cnt == v.idx) check_fields(id, v);
        if (cnt == v.restart_at) begin
          mode = ~v.mode; cx = 8'd50; cy = 8'd50;
          cp0 = {8'd3, 8'd3}; cp1 = {8'd100, 8'hCE}; cp2 = {8'd9, 8'd9};
          start = 1'b1;
        end
        if (mv_if.OUT_LAST) last_at = cnt;
        if (first < 0) first = cyc;
        lastv = cyc;
        cnt++;
      end
      if (done) done_cyc = cyc;
      @(negedge CLK);
      cyc++;
      start = 1'b0;
    end
    check($sformatf("v%0d outputs", id), 32'(cnt), 32'd16);
    check($sformatf("v%0d last_index", id), 32'(last_at), 32'd15);
    check($sformatf("v%0d done_delay", id), 32'(done_cyc - lastv), 32'd1);
    check($sformatf("v%0d span", id), 32'(lastv - first), 32'(15 + ((v.stall_at >= 0) ? 3 : 0)));
    check($sformatf("v%0d busy_after", id), 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt, cyc, dcount, vcount, vcyc, dcyc;
    bit hit;
    start = 1'b0; start1 = 1'b0; mode = 1'b0; cx = '0; cy = '0;
    cp0 = '0; cp1 = '0; cp2 = '0;
    mv_if.OUT_READY = 1'b0; mv1_if.OUT_READY = 1'b0;

    //          mode  cx     cy     h0     v0     h1     v1     h2     v2    idx ex     ey     eix       efx    eiy       efy    ix    iy    el   stall restart
    vecs[0]  = '{1'b0, 8'd0,  8'd0,  8'd16, 8'd8,  8'd16, 8'd8,  8'd0,  8'd0,  0, 8'd0,  8'd0,  15'd16,   4'd0,  15'd8,    4'd0,  1'b0, 1'b0, 1'b0, -1, -1};
    vecs[1]  = '{1'b0, 8'd0,  8'd0,  8'd16, 8'd8,  8'd16, 8'd8,  8'd0,  8'd0, 15, 8'd3,  8'd3,  15'd16,   4'd0,  15'd8,    4'd0,  1'b0, 1'b0, 1'b1, -1, -1};
    vecs[2]  = '{1'b0, 8'd10, 8'd20, 8'd0,  8'd0,  8'd4,  8'd0,  8'd0,  8'd0,  1, 8'd11, 8'd20, 15'd0,    4'd4,  15'd0,    4'd0,  1'b1, 1'b0, 1'b0, -1, -1};
    vecs[3]  = '{1'b0, 8'd10, 8'd20, 8'd0,  8'd0,  8'd4,  8'd0,  8'd0,  8'd0,  4, 8'd10, 8'd21, 15'd0,    4'd0,  15'd0,    4'd4,  1'b0, 1'b1, 1'b0, -1, -1};
    vecs[4]  = '{1'b0, 8'd10, 8'd20, 8'd0,  8'd0,  8'd4,  8'd0,  8'd0,  8'd0, 15, 8'd13, 8'd23, 15'd0,    4'd12, 15'd0,    4'd12, 1'b1, 1'b1, 1'b1, -1, -1};
    vecs[5]  = '{1'b1, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'hFE, 8, 8'd0,  8'd2,  15'd0,    4'd0,  15'h7FFF, 4'd12, 1'b0, 1'b1, 1'b0, -1, -1};
    vecs[6]  = '{1'b0, 8'hFE, 8'hFF, 8'hFF, 8'd3,  8'hFF, 8'd3,  8'd0,  8'd0,  3, 8'd1,  8'hFF, 15'h7FFF, 4'd0,  15'd3,    4'd0,  1'b0, 1'b0, 1'b0, -1, -1};
    vecs[7]  = '{1'b0, 8'hFE, 8'hFF, 8'hFF, 8'd3,  8'hFF, 8'd3,  8'd0,  8'd0, 12, 8'hFE, 8'd2,  15'h7FFF, 4'd0,  15'd3,    4'd0,  1'b0, 1'b0, 1'b0, -1, -1};
    vecs[8]  = '{1'b0, 8'd0,  8'd0,  8'd2,  8'hFD, 8'd5,  8'd1,  8'd0,  8'd0,  6, 8'd2,  8'd1,  15'd2,    4'd2,  15'h7FFD, 4'd11, 1'b1, 1'b1, 1'b0, -1, -1};
    vecs[9]  = '{1'b1, 8'd0,  8'd0,  8'd1,  8'd1,  8'd3,  8'd0,  8'hFF, 8'd5, 15, 8'd3,  8'd3,  15'd1,    4'd0,  15'd1,    4'd9,  1'b0, 1'b1, 1'b1, -1, -1};
    vecs[10] = '{1'b0, 8'd0,  8'd0,  8'd0,  8'd0,  8'd2,  8'd1,  8'd7,  8'd7,  5, 8'd1,  8'd1,  15'd0,    4'd1,  15'd0,    4'd3,  1'b1, 1'b1, 1'b0, -1, -1};
    vecs[11] = '{1'b0, 8'd0,  8'd0,  8'd2,  8'hFD, 8'd5,  8'd1,  8'd0,  8'd0,  5, 8'd1,  8'd1,  15'd1,    4'd15, 15'h7FFD, 4'd7,  1'b1, 1'b1, 1'b0,  5, -1};
    vecs[12] = '{1'b0, 8'd10, 8'd20, 8'd0,  8'd0,  8'd4,  8'd0,  8'd0,  8'd0, 15, 8'd13, 8'd23, 15'd0,    4'd12, 15'd0,    4'd12, 1'b1, 1'b1, 1'b1, -1,  3};

    repeat (3) @(negedge CLK);
    check("rst valid", 32'(mv_if.OUT_VALID), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    RST_ASYNC = 1'b0;
    @(negedge CLK);
    check("idle valid", 32'(mv_if.OUT_VALID), 32'd0);
    check("idle done", 32'(done), 32'd0);
    check("idle mv", 32'({mv_if.OUT_MV_X_INTEGER, mv_if.OUT_MV_Y_INTEGER}), 32'd0);
    check("idle xy", 32'({mv_if.OUT_X, mv_if.OUT_Y, mv_if.OUT_LAST}), 32'd0);

    for (int t = 0; t < 13; t++) run_vec(t, vecs[t]);

    // abort a block with reset while output 7 is presented
    mv_if.OUT_READY = 1'b1;
    launch(vecs[8]);
    cnt = 0; cyc = 0; hit = 1'b0;
    while (cyc < 50 && !hit) begin
      if (mv_if.OUT_VALID) begin
        if (cnt == 7) hit = 1'b1;
        else cnt++;
      end
      if (!hit) begin
        @(negedge CLK);
        cyc++;
      end
    end
    check("rst_mid reached", 32'(hit), 32'd1);
    RST_ASYNC = 1'b1;
    #1;
    check("rst_mid valid", 32'(mv_if.OUT_VALID), 32'd0);
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid xy", 32'({mv_if.OUT_X, mv_if.OUT_Y}), 32'd0);
    check("rst_mid mv", 32'({mv_if.OUT_MV_X_INTEGER, mv_if.OUT_MV_X_FRAC}), 32'd0);
    @(negedge CLK);
    RST_ASYNC = 1'b0;
    dcount = 0; vcount = 0;
    repeat (20) begin
      @(negedge CLK);
      if (done) dcount++;
      if (mv_if.OUT_VALID) vcount++;
    end
    check("rst_mid no_done", 32'(dcount), 32'd0);
    check("rst_mid no_valid", 32'(vcount), 32'd0);
    run_vec(13, vecs[0]);

    // 1x1 grid build: single output carrying LAST, then DONE
    cx = 8'd7; cy = 8'd9; mode = 1'b0;
    cp0 = {8'hFD, 8'd5}; cp1 = {8'd1, 8'd1}; cp2 = '0;
    mv1_if.OUT_READY = 1'b1;
    start1 = 1'b1;
    @(negedge CLK);
    start1 = 1'b0;
    cnt = 0; vcyc = -1; dcyc = -1;
    for (int c = 0; c < 10; c++) begin
      if (mv1_if.OUT_VALID) begin
        cnt++;
        vcyc = c;
        check("g1 last", 32'(mv1_if.OUT_LAST), 32'd1);
        check("g1 int_x", 32'(mv1_if.OUT_MV_X_INTEGER), 32'h7FFD);
        check("g1 frac_x", 32'(mv1_if.OUT_MV_X_FRAC), 32'd0);
        check("g1 int_y", 32'(mv1_if.OUT_MV_Y_INTEGER), 32'd5);
        check("g1 xy", 32'({mv1_if.OUT_X, mv1_if.OUT_Y}), 32'h0709);
      end
      if (done1) dcyc = c;
      @(negedge CLK);
    end
    check("g1 outputs", 32'(cnt), 32'd1);
    check("g1 latency", 32'(vcyc), 32'd1);
    check("g1 done_delay", 32'(dcyc - vcyc), 32'd1);
    check("g1 busy_after", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
